// File: rtl/s_box_pkg.sv
// s_box_pkg -- shared constants and GF(2^4) helpers for the AES S-box.
//
// Composite field used by the inverter:
//   GF(2^4)       : polynomial basis, x^4 + x + 1 (x^4 folds back to GF16_PHI)
//   GF((2^4)^2)   : y^2 + y + GF16_LAMBDA, byte layout {hi[3:0], lo[3:0]}
// ISO_M maps an AES-field byte into that composite layout and INV_ISO_M maps
// it back. Row i of a matrix is the mask of input bits XORed into output bit i.
package s_box_pkg;

   localparam logic [7:0] AFF_C     = 8'h63;
   localparam logic [7:0] INV_AFF_C = 8'h05;

   // Rows listed from output bit 7 down to output bit 0.
   localparam logic [7:0][7:0] ISO_M = {
      8'hA0, 8'hAC, 8'hD2, 8'h70, 8'h14, 8'h82, 8'h06, 8'h71
   };
   localparam logic [7:0][7:0] INV_ISO_M = {
      8'hB4, 8'h9E, 8'h34, 8'hBA, 8'h72, 8'hB2, 8'hB0, 8'h11
   };

   // y^2 = y + LAMBDA in the extension; x^4 = PHI in the GF(2^4) ground field.
   localparam logic [3:0] GF16_LAMBDA = 4'hE;
   localparam logic [3:0] GF16_PHI    = 4'h3;

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } gf16x2_t;

   // Shift-and-add multiply with reduction on every shift.
   function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] acc;
      logic [3:0] sh;
      acc = 4'h0;
      sh  = x;
      for (int i = 0; i < 4; i++) begin
         if (y[i]) acc = acc ^ sh;
         sh = {sh[2:0], 1'b0} ^ (sh[3] ? GF16_PHI : 4'h0);
      end
      return acc;
   endfunction

   // Squaring is linear: (sum a_i x^i)^2 = sum a_i x^(2i), then reduce.
   function automatic logic [3:0] gf16_sq(input logic [3:0] x);
      return {x[3], x[3] ^ x[1], x[2], x[2] ^ x[0]};
   endfunction

   // x^-1 = x^14 = x^2 * x^4 * x^8; maps 0 to 0 as required.
   function automatic logic [3:0] gf16_inv(input logic [3:0] x);
      logic [3:0] x2;
      logic [3:0] x4;
      logic [3:0] x8;
      x2 = gf16_sq(x);
      x4 = gf16_sq(x2);
      x8 = gf16_sq(x4);
      return gf16_mul(x2, gf16_mul(x4, x8));
   endfunction

endpackage

// File: rtl/s_box_gf256_inv.sv
// gf256_inv -- combinational GF(2^8) multiplicative inverse (AES polynomial
// x^8+x^4+x^3+x+1), computed in the composite field GF((2^4)^2).
// Ports:
//   i_a   [7:0] in   AES-field byte
//   o_inv [7:0] out  inverse of i_a (0 maps to 0)
module gf256_inv
   import s_box_pkg::*;
(
   input  logic [7:0] i_a,
   output logic [7:0] o_inv
);

   logic [7:0] w_iso;
   gf16x2_t    w_c;
   gf16x2_t    w_r;
   logic [3:0] w_d_inv;
   logic [3:0] w_d;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_iso
         assign w_iso[gi] = ^(ISO_M[gi] & i_a);
      end
   endgenerate

   assign w_c = gf16x2_t'(w_iso);

   // (hi*y + lo)^-1 = hi*d*y + (hi+lo)*d, d = (hi^2*LAMBDA + hi*lo + lo^2)^-1
   assign w_d_inv = gf16_mul(gf16_sq(w_c.hi), GF16_LAMBDA)
                  ^ gf16_mul(w_c.hi, w_c.lo)
                  ^ gf16_sq(w_c.lo);
   assign w_d     = gf16_inv(w_d_inv);
   assign w_r.hi  = gf16_mul(w_c.hi, w_d);
   assign w_r.lo  = gf16_mul(w_c.hi ^ w_c.lo, w_d);

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_inv_iso
         assign o_inv[gi] = ^(INV_ISO_M[gi] & w_r);
      end
   endgenerate

endmodule

// File: rtl/s_box.sv
// s_box -- AES forward / inverse S-box around one shared GF(2^8) inverter.
// Ports:
//   clk   in        rising-edge clock (unused when REG_OUT = 0)
//   rst_n in        asynchronous active-low reset of q (unused when REG_OUT = 0)
//   a     in  [7:0] byte to substitute
//   enc   in        1 = SubBytes, 0 = InvSubBytes
//   q     out [7:0] substituted byte; registered (1-cycle latency) when REG_OUT = 1
module s_box
   import s_box_pkg::*;
#(
   parameter int REG_OUT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic       enc,
   output logic [7:0] q
);

   logic [7:0] w_inv_aff;
   logic [7:0] w_inv_in;
   logic [7:0] w_inv_out;
   logic [7:0] w_aff;
   logic [7:0] w_sub;

   // Affine maps written per bit as cyclic XORs of the input byte.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_affine
         assign w_inv_aff[gi] = a[(gi + 2) % 8] ^ a[(gi + 5) % 8] ^ a[(gi + 7) % 8]
                              ^ INV_AFF_C[gi];
         assign w_aff[gi]     = w_inv_out[gi] ^ w_inv_out[(gi + 4) % 8]
                              ^ w_inv_out[(gi + 5) % 8] ^ w_inv_out[(gi + 6) % 8]
                              ^ w_inv_out[(gi + 7) % 8] ^ AFF_C[gi];
      end
   endgenerate

   // Decryption applies the inverse affine before inverting, encryption after.
   assign w_inv_in = enc ? a : w_inv_aff;

   gf256_inv u_inv (
      .i_a   (w_inv_in),
      .o_inv (w_inv_out)
   );

   assign w_sub = enc ? w_aff : w_inv_out;

   generate
      if (REG_OUT != 0) begin : g_reg
         logic [7:0] r_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_q <= 8'h00;
            else        r_q <= w_sub;
         end
         assign q = r_q;
      end else begin : g_comb
         assign q = w_sub;
      end
   endgenerate

endmodule

// File: tb/tb_s_box.sv
module tb_s_box;

   typedef struct {
      string      name;
      logic       enc;
      logic [7:0] a;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] d_a;
   logic       d_enc;
   logic [7:0] d_q;

   logic       tie_clk   = 1'b0;
   logic       tie_rst_n = 1'b1;
   logic [7:0] rt_a;
   logic [7:0] rt_mid;
   logic [7:0] rt_q;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] fwd_tbl [256];
   logic [7:0] inv_tbl [256];

   always #5 clk = ~clk;

   s_box #(.REG_OUT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (d_a),
      .enc   (d_enc),
      .q     (d_q)
   );

   // Combinational pair: forward feeding inverse, no clock applied.
   s_box #(.REG_OUT(0)) u_fwd (
      .clk   (tie_clk),
      .rst_n (tie_rst_n),
      .a     (rt_a),
      .enc   (1'b1),
      .q     (rt_mid)
   );

   s_box #(.REG_OUT(0)) u_inv (
      .clk   (tie_clk),
      .rst_n (tie_rst_n),
      .a     (rt_mid),
      .enc   (1'b0),
      .q     (rt_q)
   );

   // ---------------- reference model: plain GF(2^8) arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ s;
         s = s[7] ? ((s << 1) ^ 8'h1B) : (s << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] aff_ref(input logic [7:0] x);
      logic [7:0] c;
      logic [7:0] r;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         r[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8]
              ^ x[(i + 7) % 8] ^ c[i];
      return r;
   endfunction

   task automatic build_model();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         fwd_tbl[x] = aff_ref(inv);
      end
      // InvSubBytes is the inverse permutation of SubBytes.
      for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
   endtask

   function automatic logic [7:0] model(input logic [7:0] x, input logic e);
      return e ? fwd_tbl[x] : inv_tbl[x];
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: q=%02h expected %02h", name, act, exp);
      end else begin
         $display("ok   %s: q=%02h", name, act);
      end
   endtask

   // Drive away from the active edge, sample 1 time unit after it.
   task automatic apply(input logic [7:0] av, input logic ev);
      @(negedge clk);
      d_a   = av;
      d_enc = ev;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [8];

   initial begin
      vecs[0] = '{"fwd_00", 1'b1, 8'h00, 8'h63};
      vecs[1] = '{"fwd_01", 1'b1, 8'h01, 8'h7C};
      vecs[2] = '{"fwd_53", 1'b1, 8'h53, 8'hED};
      vecs[3] = '{"fwd_FF", 1'b1, 8'hFF, 8'h16};
      vecs[4] = '{"inv_63", 1'b0, 8'h63, 8'h00};
      vecs[5] = '{"inv_7C", 1'b0, 8'h7C, 8'h01};
      vecs[6] = '{"inv_ED", 1'b0, 8'hED, 8'h53};
      vecs[7] = '{"inv_16", 1'b0, 8'h16, 8'hFF};

      rst_n = 1'b0;
      d_a   = 8'h00;
      d_enc = 1'b1;
      rt_a  = 8'h00;
      build_model();

      // Reset state, before any clock edge.
      #3;
      check("reset_q", d_q, 8'h00);

      // First edge after release loads the current result.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_load", d_q, 8'h63);

      // Known-answer table.
      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].enc);
         check(vecs[i].name, d_q, vecs[i].exp);
      end

      // Mode toggle with a held at 53.
      apply(8'h53, 1'b1);
      check("toggle_enc1", d_q, 8'hED);
      apply(8'h53, 1'b0);
      check("toggle_enc0", d_q, 8'h50);
      apply(8'h53, 1'b1);
      check("toggle_enc1b", d_q, 8'hED);

      // Reset between edges clears immediately; release loads on next edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", d_q, 8'h00);
      @(posedge clk);
      #1;
      check("rst_hold", d_q, 8'h00);
      @(negedge clk);
      d_a   = 8'h01;
      d_enc = 1'b1;
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_release_wait", d_q, 8'h00);
      @(posedge clk);
      #1;
      check("rst_reload", d_q, 8'h7C);

      // Randomized stream against the model.
      for (int n = 0; n < 200; n++) begin
         logic [7:0] ra;
         logic       re;
         ra = 8'($urandom_range(0, 255));
         re = 1'($urandom_range(0, 1));
         apply(ra, re);
         check($sformatf("rand a=%02h enc=%0d", ra, re), d_q, model(ra, re));
      end

      // Combinational instance, no clock on it.
      rt_a = 8'h01;
      #1;
      check("comb_01", rt_mid, 8'h7C);

      // Exhaustive forward and round trip through the combinational pair.
      for (int x = 0; x < 256; x++) begin
         rt_a = 8'(x);
         #1;
         check($sformatf("comb_fwd a=%02h", x), rt_mid, fwd_tbl[x]);
         check($sformatf("round_trip a=%02h", x), rt_q, 8'(x));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/s_box.md
S_BOX -- requirements
Module: s_box

Interface
REQ-001 Parameter REG_OUT, default 1: 1 = registered output with 1-cycle latency; 0 = purely combinational q, with clk and rst_n unused.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  8  byte to substitute.
REQ-005 enc  input  1  mode select: 1 = forward AES S-box (encryption), 0 = inverse AES S-box (decryption).
REQ-006 q  output  8  substituted byte.

Function
REQ-007 enc=1: q SHALL equal SubBytes(a) = Aff(Inv(a)).
- Aff(x)_i = x_i ^ x_(i+4)%8 ^ x_(i+5)%8 ^ x_(i+6)%8 ^ x_(i+7)%8 ^ c_i.
- c = 8'h63.
REQ-008 enc=0: q SHALL equal InvSubBytes(a) = Inv(InvAff(a)).
- InvAff(x)_i = x_(i+2)%8 ^ x_(i+5)%8 ^ x_(i+7)%8 ^ d_i.
- d = 8'h05.
REQ-009 Inv(x) SHALL be the multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1; Inv(8'h00) = 8'h00.
REQ-010 A single shared inverter SHALL serve both modes.
- Input mux: enc ? a : InvAff(a).
- Output mux: enc ? Aff(inv) : inv.
REQ-011 The inverter SHALL be built in composite field GF((2^4)^2), with isomorphism mapping in and out. Lookup tables are not permitted.
REQ-012 REG_OUT=1: q SHALL be updated on every rising clk edge with the function of the a/enc values sampled at that edge. Latency is exactly 1 cycle; throughput is 1 byte per cycle; there is no handshake.
REQ-013 Toggling enc on consecutive cycles SHALL produce each cycle's result independently; the block holds no state other than the q register.
REQ-014 REG_OUT=0: q SHALL settle combinationally from a and enc with no storage.
REQ-015 Every input byte 00..FF is legal. For every x, InvSubBytes(SubBytes(x)) = x.

Reset
REQ-016 While rst_n=0, the q register SHALL asynchronously clear to 8'h00, independent of clk.
REQ-017 On the first rising clk edge after rst_n deasserts, q SHALL load the S-box result of the current a/enc.
REQ-018 Reset asserted mid-stream SHALL immediately force q=8'h00. No partial result SHALL survive reset.

Structure
REQ-019 A shared package s_box_pkg SHALL hold:
- constants AFF_C = 8'h63 and INV_AFF_C = 8'h05;
- the 8x8 isomorphism and inverse-isomorphism bit matrices;
- the GF(2^4) constants (lambda, phi).
REQ-020 One sub-module, gf256_inv (8-bit combinational composite-field inverter), SHALL be instantiated exactly once. The affine transforms, muxes and output register stay in s_box.

Verification
REQ-021 Exhaustive round trip: for a = 00..FF, drive a forward instance (enc=1) into an inverse instance (enc=0) -> final output equals a for all 256 values, 0 mismatches.
REQ-022 Forward vectors, enc=1 -> q one cycle later:
- a=00 -> 63; a=01 -> 7C; a=53 -> ED; a=FF -> 16.
REQ-023 Inverse vectors, enc=0:
- a=63 -> 00; a=7C -> 01; a=ED -> 53; a=16 -> FF.
REQ-024 Mode toggle: hold a=53 and alternate enc 1,0,1 on successive cycles -> q = ED, 50, ED (InvSubBytes(53) = 50).
REQ-025 Reset mid-operation: with q=ED, assert rst_n=0 between clock edges -> q=00 immediately. Release rst_n -> next edge loads the current result.
REQ-026 With REG_OUT=0: a=01, enc=1 -> q=7C with no clock applied.
